// File: rtl/word_screen_pkg.sv
// Shared definitions for the word-area screen drawing controller: phase codes,
// phase lengths, colours and the per-phase lookup helpers.
package word_screen_pkg;

   typedef enum logic [2:0] {
      PH_IDLE      = 3'd0,
      PH_CLEAR     = 3'd1,
      PH_ULINE     = 3'd2,
      PH_LETTERS   = 3'd3,
      PH_ERASE_BOX = 3'd4,
      PH_BOX       = 3'd5,
      PH_FIN       = 3'd6
   } phase_t;

   localparam int         CNT_W           = 9;
   localparam int         POS_W           = 4;
   localparam int         MAX_POS_DEFAULT = 9;

   localparam logic [CNT_W-1:0] LEN_CLEAR   = 9'd328;
   localparam logic [CNT_W-1:0] LEN_ULINE   = 9'd40;
   localparam logic [CNT_W-1:0] LEN_LETTERS = 9'd160;
   localparam logic [CNT_W-1:0] LEN_BOX     = 9'd16;

   localparam logic [2:0] COL_BG   = 3'b000;
   localparam logic [2:0] COL_TEXT = 3'b111;
   localparam logic [2:0] COL_BOX  = 3'b110;

   // Request that is waiting for the running sequence to finish.
   typedef struct packed {
      logic             full;
      logic             cursor;
      logic [POS_W-1:0] pos;
   } draw_req_t;

   function automatic logic is_draw(phase_t p);
      return (p == PH_CLEAR) || (p == PH_ULINE) || (p == PH_LETTERS) ||
             (p == PH_ERASE_BOX) || (p == PH_BOX);
   endfunction

   function automatic logic [CNT_W-1:0] phase_len(phase_t p);
      case (p)
         PH_CLEAR:     return LEN_CLEAR;
         PH_ULINE:     return LEN_ULINE;
         PH_LETTERS:   return LEN_LETTERS;
         PH_ERASE_BOX: return LEN_BOX;
         PH_BOX:       return LEN_BOX;
         default:      return 9'd1;
      endcase
   endfunction

   function automatic logic [2:0] phase_colour(phase_t p);
      case (p)
         PH_ULINE, PH_LETTERS: return COL_TEXT;
         PH_BOX:               return COL_BOX;
         default:              return COL_BG;
      endcase
   endfunction

   // Successor of a drawing phase once its last pixel has been written.
   function automatic phase_t next_phase(phase_t p);
      case (p)
         PH_CLEAR:     return PH_ULINE;
         PH_ULINE:     return PH_LETTERS;
         PH_LETTERS:   return PH_BOX;
         PH_ERASE_BOX: return PH_BOX;
         PH_BOX:       return PH_FIN;
         default:      return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/word_screen_ctrl_phase_counter.sv
// Pixel index counter for one drawing phase: clear to zero, increment, and flag
// the last index of a phase whose length is supplied by the caller.
module phase_counter #(
   parameter int W = 9
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clear,
   input  logic         inc,
   input  logic [W-1:0] len,
   output logic [W-1:0] cnt,
   output logic         tc
);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)    cnt <= '0;
      else if (clear) cnt <= '0;
      else if (inc)   cnt <= cnt + W'(1);
   end

   assign tc = (cnt == len - W'(1));

endmodule

// File: rtl/word_screen_ctrl.sv
// Word-area redraw sequencer: steps through clear/underline/letters/box phases
// (or erase-box/box for a cursor move) emitting one pixel strobe per cycle.
module word_screen_ctrl
   import word_screen_pkg::*;
#(
   parameter int MAX_POS = MAX_POS_DEFAULT
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             req_full,
   input  logic             req_cursor,
   input  logic [POS_W-1:0] letter_num,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] count,
   output logic [POS_W-1:0] box_pos,
   output logic [2:0]       colour,
   output logic             plot,
   output logic             busy,
   output logic             done
);

   phase_t           state, state_n;
   draw_req_t        pend, pend_n;
   logic [POS_W-1:0] target, target_n;
   logic [POS_W-1:0] old_pos, old_pos_n;
   logic [POS_W-1:0] req_pos;
   logic             cnt_clear, cnt_inc, cnt_tc;
   logic             eff_full, eff_cursor;
   logic [POS_W-1:0] eff_pos;

   assign req_pos = (letter_num > POS_W'(MAX_POS)) ? POS_W'(MAX_POS) : letter_num;

   // At the end of FIN a request arriving that very cycle is merged with the
   // latched ones, so nothing is lost on the sequence boundary.
   assign eff_full   = pend.full | req_full;
   assign eff_cursor = (pend.cursor | req_cursor) & ~eff_full;
   assign eff_pos    = (req_full | req_cursor) ? req_pos : pend.pos;

   phase_counter #(.W(CNT_W)) u_cnt (
      .clock  (clock),
      .resetn (resetn),
      .clear  (cnt_clear),
      .inc    (cnt_inc),
      .len    (phase_len(state)),
      .cnt    (count),
      .tc     (cnt_tc)
   );

   always_comb begin
      state_n   = state;
      pend_n    = pend;
      target_n  = target;
      old_pos_n = old_pos;
      cnt_clear = 1'b1;
      cnt_inc   = 1'b0;
      case (state)
         PH_IDLE: begin
            if (req_full) begin
               state_n  = PH_CLEAR;
               target_n = req_pos;
            end else if (req_cursor) begin
               state_n  = PH_ERASE_BOX;
               target_n = req_pos;
            end
         end
         PH_FIN: begin
            pend_n.full   = 1'b0;
            pend_n.cursor = 1'b0;
            if (eff_full) begin
               state_n  = PH_CLEAR;
               target_n = eff_pos;
            end else if (eff_cursor) begin
               state_n  = PH_ERASE_BOX;
               target_n = eff_pos;
            end else begin
               state_n = PH_IDLE;
            end
         end
         default: begin
            // A pending full redraw also redraws the box, so it swallows any cursor move.
            if (req_full) begin
               pend_n.full   = 1'b1;
               pend_n.cursor = 1'b0;
               pend_n.pos    = req_pos;
            end else if (req_cursor) begin
               pend_n.cursor = ~pend.full;
               pend_n.pos    = req_pos;
            end
            if (cnt_tc) begin
               state_n = next_phase(state);
               if (state == PH_BOX) old_pos_n = target;
            end else begin
               cnt_clear = 1'b0;
               cnt_inc   = 1'b1;
            end
         end
      endcase
   end

   // Outputs are registered from the next-state values so they line up with count.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= PH_IDLE;
         pend    <= '0;
         target  <= '0;
         old_pos <= '0;
         phase   <= PH_IDLE;
         box_pos <= '0;
         colour  <= COL_BG;
         plot    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         pend    <= pend_n;
         target  <= target_n;
         old_pos <= old_pos_n;
         phase   <= state_n;
         box_pos <= (state_n == PH_ERASE_BOX) ? old_pos_n : target_n;
         colour  <= phase_colour(state_n);
         plot    <= is_draw(state_n);
         busy    <= (state_n != PH_IDLE);
         done    <= (state_n == PH_FIN);
      end
   end

endmodule

// File: tb/tb_word_screen_ctrl.sv
// Randomised bench for word_screen_ctrl: a sequence-level model pushes every
// expected pixel and done pulse into a scoreboard that a monitor drains.
module tb_word_screen_ctrl;
   import word_screen_pkg::*;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       req_full = 1'b0;
   logic       req_cursor = 1'b0;
   logic [3:0] letter_num = 4'd0;
   logic [2:0] phase;
   logic [8:0] count;
   logic [3:0] box_pos;
   logic [2:0] colour;
   logic       plot, busy, done;

   word_screen_ctrl #(.MAX_POS(9)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .req_full   (req_full),
      .req_cursor (req_cursor),
      .letter_num (letter_num),
      .phase      (phase),
      .count      (count),
      .box_pos    (box_pos),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      bit         is_done;
      bit         chk_pos;
      logic [2:0] ph;
      logic [8:0] cnt;
      logic [2:0] col;
      logic [3:0] pos;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         cyc = 0;
   int         left = 0;
   int         push_k = 0;
   int         n_vec = 0;
   int         n_err = 0;
   bit         p_full = 0, p_cur = 0;
   bit         m_f, m_c;
   logic [3:0] p_pos = 0, m_old = 0, m_ps;

   function automatic logic [3:0] clampv(logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   task automatic push_run(logic [2:0] ph, int len, logic [2:0] col, bit cp, logic [3:0] pos);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.cyc = cyc + push_k; e.is_done = 0; e.chk_pos = cp;
         e.ph = ph; e.cnt = 9'(i); e.col = col; e.pos = pos;
         sb.push_back(e);
         push_k++;
      end
   endtask

   // Whole sequence expected from the edge where it is accepted.
   task automatic start_seq(bit full, logic [3:0] pos);
      exp_t e;
      push_k = 0;
      if (full) begin
         push_run(PH_CLEAR,   328, 3'b000, 0, pos);
         push_run(PH_ULINE,    40, 3'b111, 0, pos);
         push_run(PH_LETTERS, 160, 3'b111, 0, pos);
         push_run(PH_BOX,      16, 3'b110, 1, pos);
      end else begin
         push_run(PH_ERASE_BOX, 16, 3'b000, 1, m_old);
         push_run(PH_BOX,       16, 3'b110, 1, pos);
      end
      e.cyc = cyc + push_k; e.is_done = 1; e.chk_pos = 0;
      e.ph = PH_FIN; e.cnt = 9'd0; e.col = 3'b000; e.pos = pos;
      sb.push_back(e);
      left = push_k + 1;
      m_old = pos;
   endtask

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sb.delete();
         left = 0; p_full = 0; p_cur = 0; m_old = 0;
      end else begin
         cyc++;
         if (left == 0) begin
            if (req_full)        start_seq(1, clampv(letter_num));
            else if (req_cursor) start_seq(0, clampv(letter_num));
         end else if (left == 1) begin
            m_f  = p_full | req_full;
            m_c  = (p_cur | req_cursor) & ~m_f;
            m_ps = (req_full | req_cursor) ? clampv(letter_num) : p_pos;
            p_full = 0; p_cur = 0; left = 0;
            if (m_f)      start_seq(1, m_ps);
            else if (m_c) start_seq(0, m_ps);
         end else begin
            left--;
            if (req_full | req_cursor) p_pos = clampv(letter_num);
            if (req_full) begin p_full = 1; p_cur = 0; end
            else if (req_cursor && !p_full) p_cur = 1;
         end
      end
   end

   always @(negedge clock) begin
      if (resetn) begin
         n_vec++;
         if (busy !== (left != 0)) begin
            n_err++;
            $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, left != 0);
         end
         if (plot === 1'b1 || done === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL spurious cyc=%0d: got plot=%b done=%b ph=%0d want nothing", cyc, plot, done, phase);
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.cyc != cyc || plot !== !mon_e.is_done || done !== mon_e.is_done ||
                   phase !== mon_e.ph || count !== mon_e.cnt || colour !== mon_e.col ||
                   (mon_e.chk_pos && box_pos !== mon_e.pos)) begin
                  n_err++;
                  $display("FAIL pixel: got cyc=%0d plot=%b done=%b ph=%0d cnt=%0d col=%b pos=%0d want cyc=%0d done=%b ph=%0d cnt=%0d col=%b pos=%0d",
                           cyc, plot, done, phase, count, colour, box_pos,
                           mon_e.cyc, mon_e.is_done, mon_e.ph, mon_e.cnt, mon_e.col, mon_e.pos);
               end
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            n_vec++; n_err++;
            mon_e = sb.pop_front();
            $display("FAIL missing cyc=%0d: got no strobe want ph=%0d cnt=%0d done=%b", cyc, mon_e.ph, mon_e.cnt, mon_e.is_done);
         end
      end
   end

   task automatic pulse(bit f, bit c, logic [3:0] n);
      req_full = f; req_cursor = c; letter_num = n;
      @(negedge clock);
      req_full = 0; req_cursor = 0;
   endtask

   task automatic wait_idle(int budget);
      int n = 0;
      @(negedge clock);
      while (busy && n < budget) begin @(negedge clock); n++; end
      n_vec++;
      if (busy) begin n_err++; $display("FAIL idle_timeout: got busy=1 want 0 within %0d cycles", budget); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      repeat (3) @(negedge clock);
      n_vec++;
      if ({phase, count, box_pos, colour, plot, busy, done} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got ph=%0d cnt=%0d pos=%0d col=%b plot=%b busy=%b done=%b want all 0",
                  phase, count, box_pos, colour, plot, busy, done);
      end
      resetn = 1;
      repeat (2) @(negedge clock);

      pulse(1, 0, 4'd3);  wait_idle(1000);
      pulse(0, 1, 4'd7);  wait_idle(100);
      pulse(1, 1, 4'd2);  wait_idle(1000);
      pulse(1, 0, 4'd1);
      repeat (20) @(negedge clock);
      pulse(0, 1, 4'd8);
      repeat (100) @(negedge clock);
      pulse(0, 1, 4'd0);
      repeat (100) @(negedge clock);
      pulse(0, 1, 4'd5);  wait_idle(1000);
      pulse(0, 1, 4'd12); wait_idle(100);

      // Abort mid-LETTERS with reset.
      pulse(1, 0, 4'd4);
      n = 0;
      while (!(phase == PH_LETTERS && count == 9'd50) && n < 1000) begin @(negedge clock); n++; end
      n_vec++;
      if (n >= 1000) begin n_err++; $display("FAIL letters_wait: got no LETTERS cnt 50 want it"); end
      resetn = 0;
      #1;
      n_vec++;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got plot=%b busy=%b done=%b want 0 0 0", plot, busy, done);
      end
      repeat (3) @(negedge clock);
      n_vec++;
      if (done !== 1'b0 || plot !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: got done=%b plot=%b want 0 0", done, plot);
      end
      resetn = 1;
      repeat (20) @(negedge clock);

      for (int i = 0; i < 15000; i++) begin
         r = $urandom_range(0, 999);
         req_full   = (r < 3);
         req_cursor = (r < 1) || (r >= 3 && r < 30);
         letter_num = 4'($urandom_range(0, 15));
         @(negedge clock);
      end
      req_full = 0; req_cursor = 0;
      wait_idle(3000);
      repeat (5) @(negedge clock);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL leftover: got %0d pending expectations want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
